// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Constants and state encoding shared by the MAC array
//               sequencer and the surrounding systolic datapath.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Contents    : N_MACS, W, ACC_W, K_MAX default constants
//               sched_state_e - sequencer state encoding
// ============================================================================
package systolic_pkg;

    localparam int N_MACS = 4;   // MAC lanes in the array
    localparam int W      = 8;   // operand width
    localparam int ACC_W  = 16;  // accumulator width
    localparam int K_MAX  = 16;  // longest dot product per run

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

endpackage : systolic_pkg
`default_nettype wire

// File: rtl/mac_skew_line.sv
`default_nettype none
// ============================================================================
// Module      : mac_skew_line
// Description : Shift register that turns the operand-buffer read strobe into
//               per-lane accumulate enables, each lane one cycle behind the
//               previous one.  Tap 0 absorbs the one-cycle buffer read
//               latency, so en_o[0] is the base valid v0 and en_o[i] is v0
//               delayed by i cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk      in   clock, rising edge
//               rst_n    in   asynchronous active-low reset (flushes taps)
//               rd_en_i  in   operand-buffer read strobe
//               en_o     out  N_TAPS per-lane enables
// ============================================================================
module mac_skew_line #(
    parameter int N_TAPS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_i,
    output logic [N_TAPS-1:0] en_o
);

    logic [N_TAPS-1:0] taps_q;

    generate
        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_taps
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        taps_q[gi] <= 1'b0;
                    end else begin
                        taps_q[gi] <= rd_en_i;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        taps_q[gi] <= 1'b0;
                    end else begin
                        taps_q[gi] <= taps_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign en_o = taps_q;

endmodule : mac_skew_line
`default_nettype wire

// File: rtl/mac_array_sched.sv
`default_nettype none
// ============================================================================
// Module      : mac_array_sched
// Description : Sequencer for the MAC lane array.  On start it clears the
//               lanes, streams k operand-buffer reads, lets the skewed
//               enable wavefront drain through every lane, then pulses done
//               and marks all lane results valid.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk          in   clock, rising edge
//               rst_n        in   asynchronous active-low reset
//               start_i      in   run request (IDLE only)
//               clear_all_i  in   clear lane accumulators (IDLE only)
//               k_len_i      in   terms per run, sampled with start_i
//               busy_o       out  high in every state but IDLE
//               done_o       out  one-cycle completion pulse
//               rd_en_o      out  operand-buffer read strobe
//               rd_addr_o    out  operand-buffer address
//               mac_clr_o    out  per-lane accumulator clear
//               mac_en_o     out  per-lane accumulate enable (skewed)
//               valid_out_o  out  sticky per-lane result valid
// ============================================================================
module mac_array_sched #(
    parameter int N_MACS = systolic_pkg::N_MACS,
    parameter int K_MAX  = systolic_pkg::K_MAX,
    parameter int ADDR_W = 4,
    parameter int KL_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              clear_all_i,
    input  logic [KL_W-1:0]   k_len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [N_MACS-1:0] mac_clr_o,
    output logic [N_MACS-1:0] mac_en_o,
    output logic [N_MACS-1:0] valid_out_o
);

    import systolic_pkg::*;

    localparam int DCNT_W = $clog2(N_MACS + 1);

    sched_state_e      state_q;
    logic [KL_W-1:0]   k_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [N_MACS-1:0] mac_clr_q;
    logic [N_MACS-1:0] valid_q;
    logic [DCNT_W-1:0] drain_cnt_q;

    logic [KL_W-1:0]   k_clamp_d;
    logic              last_addr_d;

    always_comb begin
        k_clamp_d   = (k_len_i > KL_W'(K_MAX)) ? KL_W'(K_MAX) : k_len_i;
        // Address k-1 is on the bus this cycle: the final read of the run.
        last_addr_d = ((KL_W'(rd_addr_q) + KL_W'(1)) == k_q);
    end

    // Every output is a register; values are set on the edge that enters
    // the state they belong to, so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            mac_clr_q   <= '0;
            valid_q     <= '0;
            drain_cnt_q <= '0;
        end else begin
            done_q    <= 1'b0;
            mac_clr_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (k_len_i != '0) begin
                            k_q       <= k_clamp_d;
                            mac_clr_q <= '1;
                            valid_q   <= '0;
                            rd_addr_q <= '0;
                            state_q   <= ST_CLEAR;
                        end else begin
                            // Empty run: nothing to clear or feed.
                            done_q  <= 1'b1;
                            valid_q <= '1;
                            state_q <= ST_DONE;
                        end
                    end else if (clear_all_i) begin
                        mac_clr_q <= '1;
                        valid_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= '0;
                    state_q   <= ST_FEED;
                end
                ST_FEED: begin
                    if (last_addr_d) begin
                        rd_en_q     <= 1'b0;
                        drain_cnt_q <= DCNT_W'(N_MACS);
                        state_q     <= ST_DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // N_MACS cycles: the last lane's final enable is in the
                    // last DRAIN cycle.
                    if (drain_cnt_q == DCNT_W'(1)) begin
                        done_q  <= 1'b1;
                        valid_q <= '1;
                        state_q <= ST_DONE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DCNT_W'(1);
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    rd_en_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    mac_skew_line #(
        .N_TAPS (N_MACS)
    ) u_skew (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en_i (rd_en_q),
        .en_o    (mac_en_o)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_o   = rd_addr_q;
    assign mac_clr_o   = mac_clr_q;
    assign valid_out_o = valid_q;

endmodule : mac_array_sched
`default_nettype wire

// File: doc/mac_array_sched.md
# mac_array_sched

Sequencer for the 4-lane MAC array in `top_system`. It is started by `start` and issues the operand-buffer read stream for a dot product of `k_len` terms. It drives per-lane clear and skewed enable strobes so the wavefront moves through the lanes one cycle apart, then reports completion with `done`, `busy` and a sticky per-lane `valid_out`. It replaces the ad-hoc start/clear decoding in front of the MAC lanes.

## Interface
- `N_MACS`, 4, number of MAC lanes sequenced.
- `K_MAX`, 16, maximum dot-product length (terms per run).
- `ADDR_W`, 4, operand-buffer address width; must satisfy 2^ADDR_W ≥ K_MAX.
- `KL_W`, 5, width of `k_len`; must hold the value K_MAX.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  run request, sampled in IDLE only.
- `clear_all`  in  1  clear all lane accumulators, honoured in IDLE only.
- `k_len`  in  KL_W  number of terms; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at run completion.
- `rd_en`  out  1  operand-buffer read strobe. Buffer read latency is 1 cycle.
- `rd_addr`  out  ADDR_W  operand-buffer address.
- `mac_clr`  out  N_MACS  per-lane accumulator clear.
- `mac_en`  out  N_MACS  per-lane accumulate enable, skewed by lane index.
- `valid_out`  out  N_MACS  sticky "result valid" per lane.

## Operation
- All outputs are registered. On reset every output is 0 and the state is IDLE.
- **IDLE**
  - `start`=1 with `k_len`≠0: latch k = min(`k_len`, K_MAX), go to CLEAR.
  - `start`=1 with `k_len`=0: go directly to DONE. No `mac_clr`, no `rd_en`, no `mac_en`.
  - `clear_all`=1 without `start`: `mac_clr` = all ones for 1 cycle, `valid_out` cleared, stay in IDLE.
  - `start` and `clear_all` in the same cycle: `start` wins. CLEAR performs the clear anyway.
- **CLEAR** (1 cycle): `mac_clr` = all ones, `valid_out` cleared, `rd_addr` reset to 0. Go to FEED.
- **FEED** (k cycles): `rd_en`=1. `rd_addr` takes the values 0, 1, …, k-1. On the cycle with `rd_addr` = k-1, go to DRAIN.
- **Enable pipeline**
  - `rd_en` delayed by 1 cycle (buffer latency) forms the base valid v0.
  - `mac_en[i]` = v0 delayed by i further cycles.
- **DRAIN** (N_MACS cycles): a down-counter waits until the last lane's enable has fired. Then go to DONE.
- **DONE** (1 cycle): `done`=1, `valid_out` = all ones. Go to IDLE.
- `valid_out` holds until the next CLEAR, `clear_all`, or reset.
- Ignored while `busy`=1: `start`, `clear_all`, `k_len`.
- Asynchronous reset mid-run: outputs drop immediately, the skew pipeline is flushed, and no `done` is produced.
- Widths:
  - `rd_addr` never wraps, since k ≤ K_MAX ≤ 2^ADDR_W.
  - The DRAIN counter is `$clog2(N_MACS+1)` bits.

## Timing
- `start` sampled at edge t:
  - CLEAR is cycle t+1.
  - FEED is cycles t+2 … t+1+k.
  - `mac_en[i]` is high on cycles t+3+i … t+2+k+i.
  - DRAIN is cycles t+2+k … t+1+k+N_MACS.
  - `done` is on cycle t+2+k+N_MACS.
- Start-to-done latency is k+N_MACS+2 cycles. `busy` is high for exactly that many cycles.
- The `k_len`=0 path has `done` at t+1 and `busy` high for 1 cycle.
- A new `start` is accepted no earlier than the cycle after `done`. Back-to-back runs therefore have 1 IDLE cycle between them.

## Structure
- Shared package `systolic_pkg`: state encodings (IDLE, CLEAR, FEED, DRAIN, DONE) and default constants N_MACS=4, W=8, ACC_W=16, K_MAX=16. The same constants are used by `top_system`.
- Sub-module `mac_skew_line`: N_MACS-tap shift register from v0 to `mac_en[N_MACS-1:0]`, with async active-low reset. It is instantiated once.
- The FSM, address counter and drain counter stay in `mac_array_sched`.

## Test plan
- Reset, then `start` with `k_len`=4: `rd_addr` 0,1,2,3 on t+2…t+5. `mac_en[0]` high t+3…t+6 and `mac_en[3]` high t+6…t+9. `done` at t+10. `valid_out`=4'b1111 afterwards.
- `clear_all` pulse in IDLE after a completed run: `mac_clr`=4'b1111 for 1 cycle, `valid_out`→0, `busy` stays 0.
- `start` with `k_len`=0: `done` at t+1, no `rd_en`/`mac_en`/`mac_clr` activity, `busy` high 1 cycle.
- `start` with `k_len`=31 (> K_MAX): clamped to 16, last `rd_addr`=15, `done` at t+22.
- `start` and `clear_all` pulsed again during FEED of a `k_len`=4 run: both ignored, timing identical to the first scenario.
- `rst_n` asserted mid-FEED: all outputs 0 immediately, no `done`. After release, a fresh `start` with `k_len`=2 gives `done` 8 cycles later.
